evbox_out_pulser: RTL
=====================

// Module: evbox_out_pulser
// PURPOSE
//  N-channel event output driver for the LC/GC event IO box.
//  Each channel drives its io_port bit from a software/sequencer request
//  (data_out) in one of four modes: level pass-through, one-shot pulse on a
//  rising edge, one-shot pulse on any edge, or forced inactive.
//  Each channel has its own polarity; outputs are registered.
//  Sits between the event-register block and the FPGA pins.
// PARAMETERS
//  N          4   number of event channels
//  CW         16  pulse-width counter width (bits)
//  RETRIGGER  0   0: an edge arriving during a pulse is ignored; 1: the edge restarts the pulse
// PORTS
//  clk          in   1     system clock
//  reset_n      in   1     asynchronous reset, active low
//  data_out     in   N     per-channel request level (synchronous to clk)
//  mode         in   2*N   channel i uses mode[2i+1:2i]: 00 level, 01 rise-pulse, 10 edge-pulse, 11 off
//  polarity     in   N     1 = channel output inverted at the pin
//  pulse_width  in   CW    pulse length in clk cycles, shared by all channels; 0 is treated as 1
//  io_port      out  N     registered pin drive
//  busy         out  N     channel is inside a one-shot pulse
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - io_port=0, busy=0, all counters=0, edge history=0, primed=0.
//  Priming:
//   - On the first clk edge after reset release, each channel captures data_out into
//     its history register and sets primed=1.
//   - No edge is detected on that cycle, so a line already high at release does not fire.
//  Edge detection (per channel):
//   - rise = primed & data_out & ~hist
//   - any  = primed & (data_out ^ hist)
//   - hist <= data_out every cycle.
//  Per-channel FSM: IDLE / PULSE.
//   - IDLE->PULSE: mode 01 and rise, or mode 10 and any.
//     Load cnt = (pulse_width==0 ? 1 : pulse_width).
//   - PULSE: cnt decrements by 1 each cycle; PULSE->IDLE when cnt==1 at a clock edge.
//   - An edge while in PULSE: RETRIGGER=1 reloads cnt and stays in PULSE;
//     RETRIGGER=0 ignores the edge.
//   - Any change of the channel's mode field while in PULSE aborts the pulse:
//     -> IDLE, cnt=0, busy=0 on the next cycle.
//   - pulse_width is sampled only at load; later changes do not affect a running pulse.
//  Active level act_i:
//   - mode 00: data_out_i registered (1-cycle latency).
//   - mode 01 or 10: 1 while in PULSE.
//   - mode 11: 0.
//  Output:
//   - io_port_i <= act_i ^ polarity_i, one register stage.
//   - For pulse modes: edge seen at cycle k -> io_port active from cycle k+1 for exactly
//     pulse_width cycles.
//   - busy_i is registered and aligned with io_port.
//   - Polarity changes take effect 1 cycle later and may glitch the pin (software's concern).
//  Simultaneous events:
//   - Mode change and an edge in the same cycle: the new mode governs; the edge is evaluated
//     under the new mode from IDLE.
//   - Reset during a pulse: immediate abort, io_port=0.
//  Counter: CW bits, no wrap. The maximum pulse is 2^CW-1 cycles.
// TESTING
//  T1 reset: reset_n=0 with data_out=4'hF, then release
//     -> io_port=0 and busy=0 during reset; mode 01 produces no pulse after release.
//  T2 level: mode=all 00, polarity=4'b0101, data_out=4'b0011
//     -> io_port=4'b0110 one cycle later.
//  T3 rise-pulse: ch0 mode 01, pulse_width=5, data_out[0] 0->1
//     -> io_port[0]=1 for exactly 5 cycles, busy[0] aligned; the 1->0 edge gives no pulse.
//  T4 retrigger: pulse_width=8, second rising edge 3 cycles into the pulse
//     -> RETRIGGER=0: total high 8 cycles; RETRIGGER=1: total high 11 cycles.
//  T5 edge-pulse with pulse_width=0: data_out[1] toggles every 4 cycles under mode 10
//     -> one 1-cycle pulse per toggle.
//  T6 abort: mid-pulse, switch ch2 mode 01->11
//     -> io_port[2]=polarity[2] and busy[2]=0 on the next cycle; assert reset_n mid-pulse
//     -> io_port=0 asynchronously.

Source files
------------

// File: rtl/evbox_out_pulser_if.sv
// Event-output bundle between the event-register block and the pin driver.
// The master side supplies requests and configuration; the slave (driver)
// returns the registered pin levels and per-channel busy flags.
interface evbox_out_pulser_if #(
  parameter int N  = 4,
  parameter int CW = 16
);
  logic [N-1:0]   data_out;
  logic [2*N-1:0] mode;
  logic [N-1:0]   polarity;
  logic [CW-1:0]  pulse_width;
  logic [N-1:0]   io_port;
  logic [N-1:0]   busy;

  modport master (
    output data_out, mode, polarity, pulse_width,
    input  io_port, busy
  );

  modport slave (
    input  data_out, mode, polarity, pulse_width,
    output io_port, busy
  );
endinterface

// File: rtl/evbox_out_pulser.sv
// N-channel event output driver. Each channel drives its pin from data_out
// as a level, a one-shot pulse on rising edges, a one-shot pulse on any edge,
// or holds it inactive. Per-channel polarity is applied in the output register.
module evbox_out_pulser #(
  parameter int N         = 4,
  parameter int CW        = 16,
  parameter int RETRIGGER = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  evbox_out_pulser_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} state_t;

  localparam logic [1:0] M_LEVEL = 2'b00;
  localparam logic [1:0] M_RISE  = 2'b01;
  localparam logic [1:0] M_EDGE  = 2'b10;

  // A zero width would never reach the cnt==1 exit, so it is promoted to one cycle.
  function automatic logic [CW-1:0] load_width(input logic [CW-1:0] pw);
    return (pw == '0) ? CW'(1) : pw;
  endfunction

  state_t         st      [N];
  state_t         st_nxt  [N];
  logic [CW-1:0]  cnt     [N];
  logic [CW-1:0]  cnt_nxt [N];
  logic [N-1:0]   hist;
  logic           primed;
  logic [2*N-1:0] mode_q;
  logic [N-1:0]   io_q;
  logic [N-1:0]   busy_q;

  logic [N-1:0]   rise;
  logic [N-1:0]   any_edge;
  logic [N-1:0]   mode_chg;
  logic [N-1:0]   trig;
  logic [N-1:0]   act;

  // Per-channel edge detection and trigger qualification under the current mode.
  for (genvar g = 0; g < N; g++) begin : g_edge
    assign rise[g]     = primed & bus.data_out[g] & ~hist[g];
    assign any_edge[g] = primed & (bus.data_out[g] ^ hist[g]);
    assign mode_chg[g] = (bus.mode[2*g +: 2] != mode_q[2*g +: 2]);
    assign trig[g]     = ((bus.mode[2*g +: 2] == M_RISE) & rise[g]) |
                         ((bus.mode[2*g +: 2] == M_EDGE) & any_edge[g]);
  end

  // Next-state, counter and active level; a mode change drops the channel back
  // to IDLE first so a coincident edge is judged under the new mode.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      st_nxt[i]  = IDLE;
      cnt_nxt[i] = '0;
      act[i]     = 1'b0;
      if (trig[i] && (!(st[i] == PULSE && !mode_chg[i]) || (RETRIGGER != 0))) begin
        st_nxt[i]  = PULSE;
        cnt_nxt[i] = load_width(bus.pulse_width);
      end else if (st[i] == PULSE && !mode_chg[i] && cnt[i] != CW'(1)) begin
        st_nxt[i]  = PULSE;
        cnt_nxt[i] = cnt[i] - CW'(1);
      end
      case (bus.mode[2*i +: 2])
        M_LEVEL: act[i] = bus.data_out[i];
        M_RISE,
        M_EDGE:  act[i] = (st_nxt[i] == PULSE);
        default: act[i] = 1'b0;
      endcase
    end
  end

  // Channel state, edge history and registered pin/busy outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
      hist   <= '0;
      primed <= 1'b0;
      mode_q <= '0;
      io_q   <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        st[i]     <= st_nxt[i];
        cnt[i]    <= cnt_nxt[i];
        busy_q[i] <= (st_nxt[i] == PULSE);
      end
      hist   <= bus.data_out;
      primed <= 1'b1;
      mode_q <= bus.mode;
      io_q   <= act ^ bus.polarity;
    end
  end

  assign bus.io_port = io_q;
  assign bus.busy    = busy_q;

endmodule
